// File: rtl/dac_replay_seq.sv
// Replay sequencer for the DAC sample table.
// Shares one memory port between host table writes (idle only) and replay
// reads, keeps at most FIFO_DEPTH reads outstanding-or-buffered so the output
// FIFO cannot overflow, and counts output stall cycles.
module dac_replay_seq #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 256,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_run,
  input  logic [ADDR_W-1:0] cfg_length,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              running,
  output logic [15:0]       stall_cnt,
  input  logic              stall_clr
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_MAX  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_LEN  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic              run_prev_q, run_prev_d;
  logic              alive_q, alive_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
  logic [RD_LAT-1:0] rd_last_q, rd_last_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;
  logic [DATA_W:0]   fifo_mem_q [FIFO_DEPTH];

  logic              run_edge;
  logic              is_last;
  logic [CNT_W:0]    occupancy;
  logic              issue;
  logic              ret;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [DATA_W:0]   head;

  assign run_edge   = cfg_run & ~run_prev_q;
  assign is_last    = ({1'b0, addr_q} == (len_q - ONE_LEN));
  // Reads in flight plus entries already buffered are the credits in use.
  assign occupancy  = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
  assign issue      = (state_q == S_RUN) && (occupancy < DEPTH_C);
  assign ret        = rd_vld_q[RD_LAT-1];
  assign fifo_empty = (fifo_cnt_q == '0);
  assign push       = ret;
  assign pop        = ~fifo_empty & m_tready;
  assign head       = fifo_mem_q[rd_ptr_q];

  assign m_tvalid  = ~fifo_empty;
  assign m_tdata   = fifo_empty ? '0 : head[DATA_W-1:0];
  assign m_tlast   = fifo_empty ? 1'b0 : head[DATA_W];
  assign running   = (state_q != S_IDLE);
  assign stall_cnt = stall_cnt_q;

  // Sequencer FSM: next state, replay address and memory port muxing.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    run_prev_d = cfg_run;
    alive_d    = 1'b1;
    wr_ready   = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      S_IDLE: begin
        wr_ready  = alive_q & ~reset;
        mem_en    = wr_valid & wr_ready;
        mem_we    = wr_valid & wr_ready;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        if (run_edge) begin
          state_d = S_RUN;
          addr_d  = '0;
          len_d   = (cfg_length == '0) ? FULL_LEN : {1'b0, cfg_length};
        end
      end
      S_RUN: begin
        mem_en   = issue;
        mem_addr = addr_q;
        if (issue) begin
          addr_d = is_last ? '0 : addr_q + 1'b1;
          // Stopping is only honoured on a frame boundary.
          if (is_last && !cfg_run) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if ((inflight_q == '0) && fifo_empty) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read-latency tracking, credit count, FIFO pointers and stall counter.
  always_comb begin
    rd_vld_d[0]  = issue;
    rd_last_d[0] = issue & is_last;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_vld_d[i]  = rd_vld_q[i-1];
      rd_last_d[i] = rd_last_q[i-1];
    end

    inflight_d = inflight_q;
    if (issue && !ret) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!issue && ret) begin
      inflight_d = inflight_q - 1'b1;
    end

    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + 1'b1;
    end else if (pop && !push) begin
      fifo_cnt_d = fifo_cnt_q - 1'b1;
    end

    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
    end
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall_clr) begin
      stall_cnt_d = '0;
    end else if (m_tvalid && !m_tready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Control state registers; reset drops in-flight reads and FIFO contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      run_prev_q  <= 1'b0;
      alive_q     <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      inflight_q  <= '0;
      rd_vld_q    <= '0;
      rd_last_q   <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      run_prev_q  <= run_prev_d;
      alive_q     <= alive_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      inflight_q  <= inflight_d;
      rd_vld_q    <= rd_vld_d;
      rd_last_q   <= rd_last_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // FIFO storage: returned read data with its end-of-frame flag.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {rd_last_q[RD_LAT-1], mem_rdata};
    end
  end

endmodule
